// File: rtl/shared_tick_debounce_ctrl.sv
// Multi-channel button debouncer sharing one tick prescaler, with early edge detection and a
// round-robin arbitrated valid/ready event port.
module shared_tick_debounce_ctrl #(
    parameter int unsigned NUM_BTN     = 4,
    parameter int unsigned TICK_CYCLES = 100000,
    parameter int unsigned HOLD_TICKS  = 20,
    parameter int unsigned ID_W        = $clog2(NUM_BTN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] debounced_o,
    output logic               event_valid_o,
    input  logic               event_ready_i,
    output logic [ID_W-1:0]    event_id_o,
    output logic               event_press_o,
    output logic               overflow_o
);

    localparam int unsigned PresW = $clog2(TICK_CYCLES);
    localparam int unsigned TcntW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {StIdle, StHiHold, StHiWait, StLoHold} state_e;

    logic [PresW-1:0]   presc_q, presc_d;
    logic               tick;

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [TcntW-1:0]   tcnt_q  [NUM_BTN];
    logic [TcntW-1:0]   tcnt_d  [NUM_BTN];
    logic [NUM_BTN-1:0] deb_q, deb_d;
    logic [NUM_BTN-1:0] press_raise, rel_raise;

    logic [NUM_BTN-1:0] press_pend_q, press_pend_d;
    logic [NUM_BTN-1:0] rel_pend_q, rel_pend_d;
    logic [NUM_BTN-1:0] any_pend, gnt_oh, clr_press, clr_rel;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gnt_idx;
    logic               found, grant, gnt_press, slot_load;

    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               press_q, press_d;
    logic               ovf_q, ovf_d;

    // Shared prescaler
    assign tick = (presc_q == PresW'(TICK_CYCLES - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PresW'(1);
    end

    // Per-channel debounce FSMs
    always_comb begin
        deb_d       = deb_q;
        press_raise = '0;
        rel_raise   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            tcnt_d[i]  = tcnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (btn_i[i]) begin
                        deb_d[i]       = 1'b1;
                        tcnt_d[i]      = '0;
                        press_raise[i] = 1'b1;
                        state_d[i]     = StHiHold;
                    end
                end
                StHiHold: begin
                    if (tick) begin
                        if (tcnt_q[i] == TcntW'(HOLD_TICKS - 1)) begin
                            if (btn_i[i]) begin
                                state_d[i] = StHiWait;
                            end else begin
                                deb_d[i]     = 1'b0;
                                rel_raise[i] = 1'b1;
                                tcnt_d[i]    = '0;
                                state_d[i]   = StLoHold;
                            end
                        end else begin
                            tcnt_d[i] = tcnt_q[i] + TcntW'(1);
                        end
                    end
                end
                StHiWait: begin
                    if (!btn_i[i]) begin
                        deb_d[i]     = 1'b0;
                        rel_raise[i] = 1'b1;
                        tcnt_d[i]    = '0;
                        state_d[i]   = StLoHold;
                    end
                end
                StLoHold: begin
                    if (tick) begin
                        if (tcnt_q[i] == TcntW'(HOLD_TICKS - 1)) begin
                            tcnt_d[i]  = '0;
                            state_d[i] = StIdle;
                        end else begin
                            tcnt_d[i] = tcnt_q[i] + TcntW'(1);
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Round-robin scan starting at rr_q, wrapping at NUM_BTN
    assign any_pend  = press_pend_q | rel_pend_q;
    assign slot_load = !valid_q || event_ready_i;

    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end
            if (!found && any_pend[ID_W'(idx)]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    assign grant     = slot_load && found;
    assign gnt_press = press_pend_q[gnt_idx];
    assign gnt_oh    = NUM_BTN'(1) << gnt_idx;
    assign clr_press = (grant && gnt_press) ? gnt_oh : '0;
    assign clr_rel   = (grant && !gnt_press) ? gnt_oh : '0;

    always_comb begin
        press_pend_d = (press_pend_q & ~clr_press) | press_raise;
        rel_pend_d   = (rel_pend_q & ~clr_rel) | rel_raise;
        // A new event only collides if its pend bit survives this cycle's grant
        ovf_d = ovf_q
              | (|(press_raise & press_pend_q & ~clr_press))
              | (|(rel_raise & rel_pend_q & ~clr_rel));
        valid_d = valid_q;
        id_d    = id_q;
        press_d = press_q;
        rr_d    = rr_q;
        if (slot_load) begin
            valid_d = found;
        end
        if (grant) begin
            id_d    = gnt_idx;
            press_d = gnt_press;
            rr_d    = (gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q      <= '0;
            deb_q        <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            rr_q         <= '0;
            valid_q      <= 1'b0;
            id_q         <= '0;
            press_q      <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= StIdle;
                tcnt_q[i]  <= '0;
            end
        end else begin
            presc_q      <= presc_d;
            deb_q        <= deb_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            press_q      <= press_d;
            ovf_q        <= ovf_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                tcnt_q[i]  <= tcnt_d[i];
            end
        end
    end

    assign debounced_o   = deb_q;
    assign event_valid_o = valid_q;
    assign event_id_o    = id_q;
    assign event_press_o = press_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_shared_tick_debounce_ctrl.sv
// Directed self-checking bench for shared_tick_debounce_ctrl (4 channels, tick=4, hold=3).
module tb_shared_tick_debounce_ctrl;

    localparam int unsigned NB = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NB-1:0] btn_i;
    logic [NB-1:0] debounced_o;
    logic          event_valid_o;
    logic          event_ready_i;
    logic [1:0]    event_id_o;
    logic          event_press_o;
    logic          overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Accepted events encoded as id*2 + press, with the cycle they were accepted in
    int            ev_q[$];
    int            ev_cyc[$];
    int            cyc = 0;
    int            rise_cnt[NB];
    int            fall_cnt[NB];
    logic [NB-1:0] prev_deb;
    logic          mon_en = 1'b0;

    shared_tick_debounce_ctrl #(
        .NUM_BTN    (NB),
        .TICK_CYCLES(4),
        .HOLD_TICKS (3),
        .ID_W       (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .btn_i        (btn_i),
        .debounced_o  (debounced_o),
        .event_valid_o(event_valid_o),
        .event_ready_i(event_ready_i),
        .event_id_o   (event_id_o),
        .event_press_o(event_press_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (event_valid_o && event_ready_i) begin
                ev_q.push_back(int'(event_id_o) * 2 + int'(event_press_o));
                ev_cyc.push_back(cyc);
            end
            for (int i = 0; i < NB; i++) begin
                if (debounced_o[i] && !prev_deb[i]) rise_cnt[i]++;
                if (!debounced_o[i] && prev_deb[i]) fall_cnt[i]++;
            end
            prev_deb = debounced_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int get_ev(input int k);
        return (k < ev_q.size()) ? ev_q[k] : -1;
    endfunction

    function automatic int get_cyc(input int k);
        return (k < ev_cyc.size()) ? ev_cyc[k] : -100;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Leaves the bench at the start of cycle 0 after reset release
    task automatic do_reset();
        mon_en        = 1'b0;
        rst_i         = 1'b1;
        btn_i         = '0;
        event_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ev_q.delete();
        ev_cyc.delete();
        for (int i = 0; i < NB; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        prev_deb = '0;
        mon_en   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat2;
        pat2 = 16'h565F;

        // Reset state
        do_reset();
        check_eq("rst_deb", debounced_o, 0);
        check_eq("rst_valid", event_valid_o, 0);
        check_eq("rst_id", event_id_o, 0);
        check_eq("rst_press", event_press_o, 0);
        check_eq("rst_ovf", overflow_o, 0);

        // 1: bouncy press on channel 1
        do_reset();
        event_ready_i = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c == 1) check_eq("t1_deb_rise", debounced_o[1], 1);
            btn_i[1] = (c >= 10) ? 1'b1 : ((c % 4) < 2);
            step(1);
        end
        check_eq("t1_deb_end", debounced_o[1], 1);
        check_eq("t1_rises", rise_cnt[1], 1);
        check_eq("t1_falls", fall_cnt[1], 0);
        check_eq("t1_nev", ev_q.size(), 1);
        check_eq("t1_ev0", get_ev(0), 3);

        // 2: short press, bouncy release falls at the end of the hold
        do_reset();
        event_ready_i = 1'b1;
        for (int c = 0; c < 33; c++) begin
            if (c == 11) check_eq("t2_deb_c11", debounced_o[2], 1);
            if (c == 12) check_eq("t2_deb_c12", debounced_o[2], 0);
            btn_i[2] = (c < 16) ? pat2[c] : 1'b0;
            step(1);
        end
        check_eq("t2_rises", rise_cnt[2], 1);
        check_eq("t2_falls", fall_cnt[2], 1);
        check_eq("t2_nev", ev_q.size(), 2);
        check_eq("t2_ev0", get_ev(0), 5);
        check_eq("t2_ev1", get_ev(1), 4);

        // 3: simultaneous pairs on channels 0 and 3, round-robin order
        do_reset();
        event_ready_i = 1'b1;
        for (int c = 0; c < 31; c++) begin
            btn_i[0] = (c < 14);
            btn_i[3] = (c < 14);
            step(1);
        end
        check_eq("t3_nev", ev_q.size(), 4);
        check_eq("t3_ev0", get_ev(0), 1);
        check_eq("t3_ev1", get_ev(1), 7);
        check_eq("t3_ev2", get_ev(2), 0);
        check_eq("t3_ev3", get_ev(3), 6);
        check_eq("t3_b2b_a", get_cyc(1) - get_cyc(0), 1);
        check_eq("t3_b2b_b", get_cyc(3) - get_cyc(2), 1);

        // 4: stalled consumer; second release collides with a pending release
        do_reset();
        for (int c = 0; c < 61; c++) begin
            if (c == 35) check_eq("t4_ovf_c35", overflow_o, 0);
            if (c == 36) begin
                check_eq("t4_ovf_c36", overflow_o, 1);
                check_eq("t4_valid", event_valid_o, 1);
                check_eq("t4_id", event_id_o, 1);
                check_eq("t4_press", event_press_o, 1);
                check_eq("t4_deb", debounced_o[1], 0);
            end
            if (c == 40) event_ready_i = 1'b1;
            btn_i[1] = (c < 2) || (c >= 20 && c < 26);
            step(1);
        end
        // Slot press, then queued second press (press first within a channel), then release
        check_eq("t4_nev", ev_q.size(), 3);
        check_eq("t4_ev0", get_ev(0), 3);
        check_eq("t4_ev1", get_ev(1), 3);
        check_eq("t4_ev2", get_ev(2), 2);
        check_eq("t4_ovf_sticky", overflow_o, 1);
        check_eq("t4_valid_end", event_valid_o, 0);

        // 5: one-cycle reset with buttons held and an event pending
        do_reset();
        btn_i[0] = 1'b1;
        btn_i[1] = 1'b1;
        step(5);
        check_eq("t5_pre_valid", event_valid_o, 1);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        check_eq("t5_deb", debounced_o, 0);
        check_eq("t5_valid", event_valid_o, 0);
        check_eq("t5_id", event_id_o, 0);
        check_eq("t5_press", event_press_o, 0);
        check_eq("t5_ovf", overflow_o, 0);
        ev_q.delete();
        ev_cyc.delete();
        event_ready_i = 1'b1;
        step(10);
        check_eq("t5_nev", ev_q.size(), 2);
        check_eq("t5_ev0", get_ev(0), 1);
        check_eq("t5_ev1", get_ev(1), 3);
        check_eq("t5_ovf_end", overflow_o, 0);
        check_eq("t5_deb_end", debounced_o, 4'b0011);

        // 6: tick phase; release lands on the third tick after reset
        do_reset();
        event_ready_i = 1'b1;
        btn_i[0]      = 1'b1;
        step(1);
        btn_i[0] = 1'b0;
        step(10);
        check_eq("t6_deb_c11", debounced_o[0], 1);
        step(1);
        check_eq("t6_deb_c12", debounced_o[0], 0);
        step(16);
        check_eq("t6_nev", ev_q.size(), 2);
        check_eq("t6_ev0", get_ev(0), 1);
        check_eq("t6_ev1", get_ev(1), 0);
        check_eq("t6_falls", fall_cnt[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
